// File: rtl/datamem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
//   DATAMEM_ADDR_WIDTH : address width presented to datamem
//   DATA_WORD_LENGTH   : data word width
//   ARB_N_REQ          : default number of requesters
//   arb_state_e        : arbiter FSM state encoding
package datamem_arbiter_pkg;

    localparam int DATAMEM_ADDR_WIDTH = 8;
    localparam int DATA_WORD_LENGTH   = 8;
    localparam int ARB_N_REQ          = 4;

    typedef enum logic {
        ARB_S_ARB    = 1'b0,
        ARB_S_ACCESS = 1'b1
    } arb_state_e;

endpackage

// File: rtl/datamem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req_i     : request vector, one bit per requester
//   rr_ptr_i  : index with highest priority this round
//   any_req_o : at least one request is pending
//   winner_o  : first set request scanning upward from rr_ptr_i, wrapping
module rr_pick
    import datamem_arbiter_pkg::*;
#(
    parameter int  N_REQ = ARB_N_REQ,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             any_req_o,
    output logic [IDX_W-1:0] winner_o
);

    always_comb begin
        int idx;
        idx       = 0;
        any_req_o = |req_i;
        winner_o  = '0;
        // Walk from the farthest offset back to offset 0 so the requester
        // closest to rr_ptr_i is the last (and therefore winning) assignment.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if ((j == idx) && req_i[j]) begin
                    winner_o = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among N_REQ
// requesters. Each access takes two cycles: ARB latches the winner's
// request, ACCESS drives the memory and returns ack plus read data.
//   clk, reset         : clock, synchronous active-high reset
//   req, we            : per-requester request / write enable
//   addr, wdata        : flattened per-requester address / write data
//   ack                : one-hot completion pulse (ACCESS cycle)
//   rdata              : broadcast read data, valid with a read ack
//   busy               : high while in ACCESS
//   MemWrite, Address,
//   WriteData          : datamem drive
//   ReadData           : datamem combinational read data
module datamem_arbiter
    import datamem_arbiter_pkg::*;
#(
    parameter int  N_REQ  = ARB_N_REQ,
    parameter int  ADDR_W = DATAMEM_ADDR_WIDTH,
    parameter int  DATA_W = DATA_WORD_LENGTH,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    MemWrite,
    output logic [ADDR_W-1:0]       Address,
    output logic [DATA_W-1:0]       WriteData,
    input  logic [DATA_W-1:0]       ReadData
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic                lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .any_req_o (pick_any),
        .winner_o  (pick_idx)
    );

    // Select the winner's request fields with constant slice indices.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        case (state_q)
            ARB_S_ARB: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    lat_we_d    = sel_we;
                    lat_addr_d  = sel_addr;
                    lat_wdata_d = sel_wdata;
                    rr_ptr_d    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                  : pick_idx + IDX_W'(1);
                    state_d     = ARB_S_ACCESS;
                end
            end
            // ARB always follows ACCESS, so a held request is never granted
            // twice for the same transaction.
            ARB_S_ACCESS: state_d = ARB_S_ARB;
            default:      state_d = ARB_S_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_S_ARB;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
        end
    end

    // Reset gates ack and MemWrite so a reset landing in ACCESS aborts the
    // transaction without a memory write or a completion pulse.
    always_comb begin
        busy      = (state_q == ARB_S_ACCESS);
        MemWrite  = busy && lat_we_q && !reset;
        Address   = lat_addr_q;
        WriteData = lat_wdata_q;
        rdata     = ReadData;
        ack       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = busy && (grant_idx_q == IDX_W'(i)) && !reset;
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;
    import datamem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy, MemWrite;
    logic [AW-1:0]   Address;
    logic [DW-1:0]   WriteData, ReadData;

    logic [7:0]      mem [0:255];
    logic            ram_init;

    typedef struct {
        int         idx;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;

    datamem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    // Behavioural datamem: combinational read, write at posedge.
    assign ReadData = mem[Address];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[4]  <= 8'hC4;
            mem[5]  <= 8'hA7;
            mem[7]  <= 8'h77;
            mem[16] <= 8'h11;
            mem[17] <= 8'h22;
            mem[18] <= 8'h33;
            mem[19] <= 8'h44;
        end else if (MemWrite) begin
            mem[Address] <= WriteData;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack pops the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (ack !== '0) begin
            if (expq.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = expq.pop_front();
                check("ack_onehot", 32'($onehot(ack)), 32'd1);
                check("ack_idx", 32'(ack), 32'(1 << e.idx));
                check("busy_in_ack", 32'(busy), 32'd1);
                check("Address", 32'(Address), 32'(e.a));
                check("MemWrite", 32'(MemWrite), 32'(e.w));
                if (e.w) check("WriteData", 32'(WriteData), 32'(e.d));
                else     check("rdata", 32'(rdata), 32'(e.d));
            end
        end
    end

    task automatic expect_acc(input int idx, input bit w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.idx = idx; e.w = w; e.a = a; e.d = d;
        expq.push_back(e);
    endtask

    task automatic raise(input int idx, input bit w, input logic [7:0] a, input logic [7:0] d);
        req[idx] = 1'b1;
        we[idx]  = w;
        addr[idx*AW +: AW]  = a;
        wdata[idx*DW +: DW] = d;
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        while (1) begin
            @(negedge clk);
            cnt++;
            if (ack != '0) break;
            if (cnt >= 40) begin
                check("ack_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    // Wait for n acks; each acked requester drops req after its ack edge.
    task automatic serve(input int n);
        int c;
        logic [N-1:0] a;
        repeat (n) begin
            wait_ack(c);
            a = ack;
            @(posedge clk);
            #1;
            req = req & ~a;
            we  = we & ~a;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c;
        reset    = 1'b1;
        ram_init = 1'b1;
        req      = '1;
        we       = '0;
        wdata    = '0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 8'(16 + i);

        // Reset state, with all requests already pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_MemWrite", 32'(MemWrite), 32'd0);
        check("rst_Address", 32'(Address), 32'd0);
        check("rst_WriteData", 32'(WriteData), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ram_init = 1'b0;

        // Full contention: 0,1,2,3,0 with one ack every two cycles
        expect_acc(0, 0, 8'd16, 8'h11);
        expect_acc(1, 0, 8'd17, 8'h22);
        expect_acc(2, 0, 8'd18, 8'h33);
        expect_acc(3, 0, 8'd19, 8'h44);
        expect_acc(0, 0, 8'd16, 8'h11);
        for (int k = 0; k < 5; k++) begin
            wait_ack(c);
            check("contention_interval", 32'(c), 32'd2);
        end
        @(posedge clk);
        #1;
        req = '0;

        // Single read, one-cycle latency from request
        expect_acc(2, 0, 8'd5, 8'hA7);
        raise(2, 0, 8'd5, 8'h00);
        wait_ack(c);
        check("read_latency", 32'(c), 32'd2);
        @(posedge clk);
        #1;
        req[2] = 1'b0;

        // Write then read back
        expect_acc(1, 1, 8'd9, 8'h3C);
        raise(1, 1, 8'd9, 8'h3C);
        serve(1);
        expect_acc(0, 0, 8'd9, 8'h3C);
        raise(0, 0, 8'd9, 8'h00);
        serve(1);

        // Pointer wraps after requester 3
        expect_acc(3, 0, 8'd16, 8'h11);
        raise(3, 0, 8'd16, 8'h00);
        serve(1);
        expect_acc(0, 0, 8'd17, 8'h22);
        expect_acc(2, 0, 8'd18, 8'h33);
        raise(0, 0, 8'd17, 8'h00);
        raise(2, 0, 8'd18, 8'h00);
        serve(2);

        // Reset during ACCESS of a write
        raise(1, 1, 8'd12, 8'hEE);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        req[1] = 1'b0;
        we[1]  = 1'b0;
        @(negedge clk);
        check("rstacc_ack", 32'(ack), 32'd0);
        check("rstacc_MemWrite", 32'(MemWrite), 32'd0);
        check("rstacc_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstacc_busy_after", 32'(busy), 32'd0);
        check("rstacc_ram", 32'(mem[12]), 32'd0);
        // rr_ptr back at 0: requester 1 beats requester 2
        expect_acc(1, 0, 8'd12, 8'h00);
        expect_acc(2, 0, 8'd12, 8'h00);
        raise(1, 0, 8'd12, 8'h00);
        raise(2, 0, 8'd12, 8'h00);
        serve(2);

        // Inputs changed during ACCESS do not affect the transaction
        expect_acc(0, 0, 8'd4, 8'hC4);
        raise(0, 0, 8'd4, 8'h00);
        @(posedge clk);
        #1;
        addr[0 +: AW]  = 8'd7;
        we[0]          = 1'b1;
        wdata[0 +: DW] = 8'hFF;
        serve(1);
        check("latched_mem7", 32'(mem[7]), 32'h77);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
